operand_fetch: RTL

//  Register-file read initiator between decode and execute: drives rs1/rs2 to the register file,

---
 rtl/opfetch_pkg.sv | 40 ++++
 rtl/operand_fetch_reg_scoreboard.sv | 48 ++++
 rtl/operand_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/opfetch_pkg.sv
// Shared constants, the operand bundle type and the write-back/forwarding helpers
// used by operand_fetch and its busy scoreboard.
package opfetch_pkg;

  localparam int XLEN   = 32;
  localparam int REGW   = 5;
  localparam int NREG   = 32;
  localparam int STALLW = 16;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [REGW-1:0] rd;
    logic            writes_rd;
  } opf_bundle_t;

  function automatic logic wb_hit(input logic            wb_regwrite,
                                  input logic [REGW-1:0] wb_rd,
                                  input logic [REGW-1:0] r);
    return wb_regwrite && (wb_rd == r) && (r != {REGW{1'b0}});
  endfunction

  // x0 and unused sources read as zero; fwd selects the same-cycle writeback value
  function automatic logic [XLEN-1:0] resolve_operand(input logic            use_op,
                                                      input logic [REGW-1:0] idx,
                                                      input logic            fwd,
                                                      input logic [XLEN-1:0] wb_data,
                                                      input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] val;
    if (!use_op || (idx == {REGW{1'b0}})) begin
      val = {XLEN{1'b0}};
    end else if (fwd) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback.
// Set beats clear on the same index; x0 is never busy.
module reg_scoreboard
  import opfetch_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            set_en,
  input  logic [REGW-1:0] set_idx,
  input  logic            clr_en,
  input  logic [REGW-1:0] clr_idx,
  input  logic [REGW-1:0] chk1_idx,
  output logic            chk1_busy,
  input  logic [REGW-1:0] chk2_idx,
  output logic            chk2_busy,
  input  logic [REGW-1:0] chkd_idx,
  output logic            chkd_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Next busy vector: clear first, then set, so a same-cycle set survives; bit 0 forced low
  always_comb begin
    set_mask_s = set_en ? (NREG'(1) << set_idx) : {NREG{1'b0}};
    clr_mask_s = clr_en ? (NREG'(1) << clr_idx) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NREG'(1);
  end

  // Busy bit storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookup ports, x0 masked
  always_comb begin
    chk1_busy = (chk1_idx != {REGW{1'b0}}) && busy_q[chk1_idx];
    chk2_busy = (chk2_idx != {REGW{1'b0}}) && busy_q[chk2_idx];
    chkd_busy = (chkd_idx != {REGW{1'b0}}) && busy_q[chkd_idx];
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard-checked issue into a 1-entry operand register.
// Optional macro BYPASS_EN forwards same-cycle writeback data and unblocks on a writeback hit.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REGW-1:0]   in_rs1,
  input  logic [REGW-1:0]   in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REGW-1:0]   in_rd,
  input  logic              in_writes_rd,
  output logic [REGW-1:0]   rs1,
  output logic [REGW-1:0]   rs2,
  input  logic [XLEN-1:0]   read_data1,
  input  logic [XLEN-1:0]   read_data2,
  input  logic              wb_regwrite,
  input  logic [REGW-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REGW-1:0]   out_rd,
  output logic              out_writes_rd,
  output logic [STALLW-1:0] stall_count
);

`ifdef BYPASS_EN
  localparam logic BYPASS_ON = 1'b1;
`else
  localparam logic BYPASS_ON = 1'b0;
`endif

  logic              busy1_s, busy2_s, busyd_s;
  logic              fwd1_s, fwd2_s, fwdd_s;
  logic              hazard_s, in_ready_s, accept_s;
  logic [XLEN-1:0]   op1_s, op2_s;

  logic              out_valid_q, out_valid_d;
  opf_bundle_t       bundle_q, bundle_d;
  logic [STALLW-1:0] stall_q, stall_d;

  reg_scoreboard u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_en    (accept_s && in_writes_rd),
    .set_idx   (in_rd),
    .clr_en    (wb_regwrite),
    .clr_idx   (wb_rd),
    .chk1_idx  (in_rs1),
    .chk1_busy (busy1_s),
    .chk2_idx  (in_rs2),
    .chk2_busy (busy2_s),
    .chkd_idx  (in_rd),
    .chkd_busy (busyd_s)
  );

  // Hazard detection, handshake and operand selection
  always_comb begin
    fwd1_s     = BYPASS_ON && wb_hit(wb_regwrite, wb_rd, in_rs1);
    fwd2_s     = BYPASS_ON && wb_hit(wb_regwrite, wb_rd, in_rs2);
    fwdd_s     = BYPASS_ON && wb_hit(wb_regwrite, wb_rd, in_rd);
    // rd check keeps a single writer in flight per register
    hazard_s   = (in_use_rs1   && busy1_s && !fwd1_s) ||
                 (in_use_rs2   && busy2_s && !fwd2_s) ||
                 (in_writes_rd && busyd_s && !fwdd_s);
    in_ready_s = (!out_valid_q || out_ready) && !hazard_s;
    accept_s   = in_valid && in_ready_s;
    op1_s      = resolve_operand(in_use_rs1, in_rs1, fwd1_s, wb_data, read_data1);
    op2_s      = resolve_operand(in_use_rs2, in_rs2, fwd2_s, wb_data, read_data2);
  end

  // Output register and stall counter next state
  always_comb begin
    bundle_d = bundle_q;
    if (accept_s) begin
      out_valid_d        = 1'b1;
      bundle_d.op1       = op1_s;
      bundle_d.op2       = op2_s;
      bundle_d.rd        = in_rd;
      bundle_d.writes_rd = in_writes_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (in_valid && !in_ready_s && (stall_q != {STALLW{1'b1}})) begin
      stall_d = stall_q + STALLW'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_q     <= {STALLW{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      stall_q     <= stall_d;
    end
  end

  assign rs1           = in_rs1;
  assign rs2           = in_rs2;
  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_q;
  assign out_op1       = bundle_q.op1;
  assign out_op2       = bundle_q.op2;
  assign out_rd        = bundle_q.rd;
  assign out_writes_rd = bundle_q.writes_rd;
  assign stall_count   = stall_q;

endmodule
